// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin mux arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output sel,
        output busy,
        output timeout
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the {S1,S0} select of a shared 4-to-1 mux.
// A grant lasts until release, owner drop, or hold expiry.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] scan_idx;
    logic       expire;
    logic       drop;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        scan_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!pick_found && bus.req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign expire = (MAX_HOLD != 0) && (hold_q == HoldLast);
    assign drop   = bus.rel || !bus.req[sel_q];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StGrant;
                    sel_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                hold_d = hold_q + 1'b1;
                if (drop || expire) begin
                    state_d   = StIdle;
                    ptr_d     = sel_q + 2'd1;
                    // Expiry only counts as a timeout when nothing else ended the grant.
                    timeout_d = expire && !drop;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // sel keeps its last value while idle so the mux output does not glitch.
    assign bus.gnt     = (state_q == StGrant) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.sel     = sel_q;
    assign bus.busy    = (state_q == StGrant);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single grant, rotation, timeout,
// release racing expiry, and asynchronous reset mid-grant.
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [1:0] exp_sel, input logic exp_to);
        check({tag, ".gnt"}, {4'b0, bus.gnt}, 8'h00);
        check({tag, ".sel"}, {6'b0, bus.sel}, {6'b0, exp_sel});
        check({tag, ".busy"}, {7'b0, bus.busy}, 8'h00);
        check({tag, ".timeout"}, {7'b0, bus.timeout}, {7'b0, exp_to});
    endtask

    task automatic check_grant(input string tag, input logic [1:0] owner);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << owner;
        check({tag, ".gnt"}, {4'b0, bus.gnt}, {4'b0, one_hot});
        check({tag, ".sel"}, {6'b0, bus.sel}, {6'b0, owner});
        check({tag, ".busy"}, {7'b0, bus.busy}, 8'h01);
        check({tag, ".timeout"}, {7'b0, bus.timeout}, 8'h00);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.req = 4'h0;
        bus.rel = 1'b0;

        // Reset with every requester asserted.
        #1 rst_n = 1'b0;
        bus.req = 4'hF;
        #1 check_idle("reset_async", 2'd0, 1'b0);
        tick();
        check_idle("reset_held", 2'd0, 1'b0);
        rst_n = 1'b1;
        bus.req = 4'h0;
        tick();
        check_idle("after_reset", 2'd0, 1'b0);

        // Single request from requester 2, then explicit release.
        bus.req = 4'b0100;
        tick();
        check_grant("single", 2'd2);
        bus.rel = 1'b1;
        tick();
        check_idle("single_rel", 2'd2, 1'b0);
        bus.rel = 1'b0;
        bus.req = 4'h0;

        // Rotation from ptr 0 with all requesters active.
        reset_pulse();
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant($sformatf("rr%0d", i), 2'(i % 4));
            bus.rel = 1'b1;
            tick();
            check_idle($sformatf("rr%0d_idle", i), 2'(i % 4), 1'b0);
            bus.rel = 1'b0;
        end
        bus.req = 4'h0;
        tick();

        // Hold expiry: 8 granted cycles, then a one-cycle timeout pulse.
        bus.req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_grant($sformatf("hold%0d", c), 2'd0);
        end
        tick();
        check_idle("expire", 2'd0, 1'b1);
        tick();
        check_grant("regrant", 2'd0);

        // rel on hold cycle 7 coincides with expiry: plain release.
        for (int c = 1; c < 8; c++) begin
            tick();
            check_grant($sformatf("race_hold%0d", c), 2'd0);
        end
        bus.rel = 1'b1;
        tick();
        check_idle("race_rel", 2'd0, 1'b0);
        bus.rel = 1'b0;
        bus.req = 4'h0;
        tick();

        // Owner dropping its request ends the grant without a timeout.
        bus.req = 4'b1000;
        tick();
        check_grant("drop_grant", 2'd3);
        bus.req = 4'h0;
        tick();
        check_idle("drop", 2'd3, 1'b0);

        // Asynchronous reset while requester 2 owns the mux.
        bus.req = 4'b0100;
        tick();
        check_grant("mid_grant", 2'd2);
        #2 rst_n = 1'b0;
        #1 check_idle("mid_reset", 2'd0, 1'b0);
        bus.req = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();
        check_grant("post_reset", 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
